// File: rtl/imem_fetch_sequencer.sv
// Instruction-memory loader and sequential fetch engine: accepts words from a
// loader into external memory, then streams them out with stall/redirect control.
module imem_fetch_sequencer #(
  parameter int unsigned IMEM_DEPTH = 5,
  parameter logic [31:0] RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        load_ready,
  output logic        imem_we,
  output logic [31:0] imem_wa,
  output logic [31:0] imem_wd,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  state_t      r_state;
  logic [31:0] r_word_count;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_halted;

  logic        w_load_ready;
  logic        w_accept;
  logic [31:0] w_count_next;
  logic        w_pc_oob;

  // Reset gates the write handshake so no store can slip out while held in reset.
  always_comb begin
    w_load_ready = (r_state == LOAD) && !reset && (r_word_count < IMEM_DEPTH);
    w_accept     = w_load_ready && load_valid;
    w_count_next = w_accept ? (r_word_count + 32'd1) : r_word_count;
    w_pc_oob     = r_pc[31] || (r_pc >= r_word_count);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= LOAD;
      r_word_count  <= '0;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_word_count <= w_count_next;
          if (load_done || (w_count_next >= IMEM_DEPTH)) begin
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            if (w_count_next == '0) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          // Priority: redirect, then range check, then stall, then fetch.
          if (redirect) begin
            r_pc          <= redirect_target;
            r_instr_valid <= 1'b0;
          end else if (w_pc_oob) begin
            r_state       <= HALT;
            r_halted      <= 1'b1;
            r_instr_valid <= 1'b0;
          end else if (!stall) begin
            r_instr       <= imem_rd;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + 32'd1;
          end
        end
        HALT: begin
          r_halted      <= 1'b1;
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_state       <= HALT;
          r_halted      <= 1'b1;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready  = w_load_ready;
  assign imem_we     = w_accept;
  assign imem_wa     = w_accept ? r_word_count : '0;
  assign imem_wd     = w_accept ? load_data : '0;
  assign imem_a      = (r_state == RUN) ? r_pc : '0;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;

endmodule
